cok_kapili_yazmac_obegi: RTL
============================

COK_KAPILI_YAZMAC_OBEGI -- requirements
Module: cok_kapili_yazmac_obegi

Interface
REQ-001 SHALL have parameter VERI_GENISLIK, default 32, register width in bits.
REQ-002 SHALL have parameter YAZMAC_SAYISI, default 32, register count (power of 2, >=4); AW = log2(YAZMAC_SAYISI).
REQ-003 SHALL have parameter OKUMA_KAPI, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter YAZMA_KAPI, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter STACKADDR, default 32'h40060000, initial value of register 2.
REQ-006 SHALL have parameter BAYPAS, default 1, enabling same-cycle write-to-read bypass.
REQ-007 SHALL have ports: clk_i  input  1  the single clock; rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: oku_adr_i  input  OKUMA_KAPI*AW  packed read addresses (port k at bits [k*AW +: AW]); oku_deger_o  output  OKUMA_KAPI*VERI_GENISLIK  packed read data; oku_mesgul_o  output  OKUMA_KAPI  pending-write flag of addressed register.
REQ-009 SHALL have ports: yaz_i  input  YAZMA_KAPI  per-port write enable; yaz_adr_i  input  YAZMA_KAPI*AW  packed write addresses; yaz_deger_i  input  YAZMA_KAPI*VERI_GENISLIK  packed write data.
REQ-010 SHALL have ports: ayir_i  input  1  scoreboard allocate strobe; ayir_adr_i  input  AW  register being allocated; hazir_o  output  1  block initialised and accepting operations.

Function
REQ-011 SHALL implement a two-state FSM: TEMIZLE (sweep) and HAZIR (operational); rst_i asserted forces TEMIZLE with sweep counter = 0.
REQ-012 In TEMIZLE, each clock edge SHALL write register[counter] = 0 (register 2 gets STACKADDR) and increment counter; after the edge writing index YAZMAC_SAYISI-1 the FSM SHALL enter HAZIR.
REQ-013 Sweep duration SHALL be exactly YAZMAC_SAYISI clock edges after rst_i deassertion; hazir_o = 1 only in HAZIR.
REQ-014 In TEMIZLE, yaz_i and ayir_i SHALL be ignored; oku_deger_o and oku_mesgul_o are don't-care.
REQ-015 Reads SHALL be combinational; register 0 SHALL always read 0 and never be written.
REQ-016 In HAZIR, each write port with yaz_i[j]=1 and nonzero address SHALL update the register on the clock edge.
REQ-017 Two write ports targeting the same nonzero address in one cycle: port 1 (higher index) SHALL win.
REQ-018 With BAYPAS=1, a read port whose nonzero address matches an enabled write port SHALL return that port's yaz_deger_i in the same cycle (higher write port wins); with BAYPAS=0, it SHALL return the stored (old) value.
REQ-019 Scoreboard: one busy bit per register; ayir_i with nonzero ayir_adr_i SHALL set the bit on the clock edge; an enabled write to a register SHALL clear its bit.
REQ-020 Simultaneous allocate and write to the same register: set SHALL win (bit remains 1).
REQ-021 Busy bit of register 0 SHALL always be 0; oku_mesgul_o[k] = busy bit of oku_adr_i port k, except with BAYPAS=1 a same-cycle clearing write SHALL report 0.
REQ-022 Implementation SHALL be 120-400 lines RTL, no latches, generate loops over port parameters.

Reset
REQ-023 Asserting rst_i at any time (including mid-sweep or mid-write) SHALL immediately force TEMIZLE, counter 0, hazir_o = 0, all busy bits 0.
REQ-024 Register contents SHALL not be reset asynchronously; they are defined only after the sweep completes (all 0, register 2 = STACKADDR).

Verification
REQ-025 Reset then release, defaults: hazir_o = 0 for 32 edges, 1 after; read x2 -> 32'h40060000, x5 -> 0.
REQ-026 HAZIR, write port 0 x5=32'hDEADBEEF, read port 0 addr 5 same cycle -> 32'hDEADBEEF (BAYPAS=1); next cycle stored value 32'hDEADBEEF.
REQ-027 Both write ports to x7 (port0=32'h1, port1=32'h2) -> x7 reads 32'h2 next cycle; write to x0 of 32'hFFFFFFFF -> x0 reads 0.
REQ-028 ayir_i x9 -> oku_mesgul_o=1 for addr 9; same-cycle ayir x9 and write x9 -> stays 1; later write x9 alone -> 0.
REQ-029 Assert rst_i at sweep counter 10 -> hazir_o = 0 immediately; release -> full 32-edge sweep restarts, writes during sweep have no effect.

Source files
------------

// File: rtl/cok_kapili_yazmac_obegi_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// scoreboard allocate strobe and the ready indication.
interface cok_kapili_yazmac_obegi_if #(
  parameter int VERI_GENISLIK = 32,
  parameter int AW            = 5,
  parameter int OKUMA_KAPI    = 2,
  parameter int YAZMA_KAPI    = 2
);
  logic [OKUMA_KAPI*AW-1:0]            oku_adr_i;
  logic [OKUMA_KAPI*VERI_GENISLIK-1:0] oku_deger_o;
  logic [OKUMA_KAPI-1:0]               oku_mesgul_o;
  logic [YAZMA_KAPI-1:0]               yaz_i;
  logic [YAZMA_KAPI*AW-1:0]            yaz_adr_i;
  logic [YAZMA_KAPI*VERI_GENISLIK-1:0] yaz_deger_i;
  logic                                ayir_i;
  logic [AW-1:0]                       ayir_adr_i;
  logic                                hazir_o;

  modport master (
    output oku_adr_i, yaz_i, yaz_adr_i, yaz_deger_i, ayir_i, ayir_adr_i,
    input  oku_deger_o, oku_mesgul_o, hazir_o
  );

  modport slave (
    input  oku_adr_i, yaz_i, yaz_adr_i, yaz_deger_i, ayir_i, ayir_adr_i,
    output oku_deger_o, oku_mesgul_o, hazir_o
  );
endinterface

// File: rtl/cok_kapili_yazmac_obegi.sv
// Multi-port register file with a post-reset clearing sweep, optional
// write-to-read bypass and a per-register busy scoreboard.
module cok_kapili_yazmac_obegi #(
  parameter int          VERI_GENISLIK = 32,
  parameter int          YAZMAC_SAYISI = 32,
  parameter int          OKUMA_KAPI    = 2,
  parameter int          YAZMA_KAPI    = 2,
  parameter logic [31:0] STACKADDR     = 32'h40060000,
  parameter int          BAYPAS        = 1
) (
  input logic clk_i,
  input logic rst_i,
  cok_kapili_yazmac_obegi_if.slave bus
);
  localparam int AW = $clog2(YAZMAC_SAYISI);
  localparam int VW = VERI_GENISLIK;

  typedef enum logic {TEMIZLE, HAZIR} durum_t;

  durum_t                   durum_q, durum_d;
  logic [AW-1:0]            sayac_q, sayac_d;
  logic [VW-1:0]            yazmac [YAZMAC_SAYISI];
  logic [YAZMAC_SAYISI-1:0] mesgul_q, mesgul_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q  <= TEMIZLE;
      sayac_q  <= '0;
      mesgul_q <= '0;
    end else begin
      durum_q  <= durum_d;
      sayac_q  <= sayac_d;
      mesgul_q <= mesgul_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    if (durum_q == TEMIZLE) begin
      sayac_d = sayac_q + 1'b1;
      if (sayac_q == AW'(YAZMAC_SAYISI - 1))
        durum_d = HAZIR;
    end
  end

  // Writes clear busy bits first so a same-cycle allocate leaves the bit set.
  always_comb begin
    mesgul_d = mesgul_q;
    if (durum_q == HAZIR) begin
      for (int j = 0; j < YAZMA_KAPI; j++)
        if (bus.yaz_i[j])
          mesgul_d[bus.yaz_adr_i[j*AW +: AW]] = 1'b0;
      if (bus.ayir_i)
        mesgul_d[bus.ayir_adr_i] = 1'b1;
    end
    mesgul_d[0] = 1'b0;
  end

  // Storage has no reset; the sweep defines it. Later ports override earlier ones.
  always_ff @(posedge clk_i) begin
    if (durum_q == TEMIZLE) begin
      if (sayac_q != '0)
        yazmac[sayac_q] <= (sayac_q == AW'(2)) ? VW'(STACKADDR) : '0;
    end else begin
      for (int j = 0; j < YAZMA_KAPI; j++)
        if (bus.yaz_i[j] && bus.yaz_adr_i[j*AW +: AW] != '0)
          yazmac[bus.yaz_adr_i[j*AW +: AW]] <= bus.yaz_deger_i[j*VW +: VW];
    end
  end

  for (genvar k = 0; k < OKUMA_KAPI; k++) begin : g_oku
    logic [AW-1:0] adr;
    logic [VW-1:0] deger;
    logic          mesgul;

    assign adr = bus.oku_adr_i[k*AW +: AW];

    always_comb begin
      deger  = yazmac[adr];
      mesgul = mesgul_q[adr];
      if (BAYPAS != 0 && durum_q == HAZIR) begin
        for (int j = 0; j < YAZMA_KAPI; j++)
          if (bus.yaz_i[j] && bus.yaz_adr_i[j*AW +: AW] == adr) begin
            deger  = bus.yaz_deger_i[j*VW +: VW];
            mesgul = 1'b0;
          end
      end
      if (adr == '0) begin
        deger  = '0;
        mesgul = 1'b0;
      end
    end

    assign bus.oku_deger_o[k*VW +: VW] = deger;
    assign bus.oku_mesgul_o[k]         = mesgul;
  end

  assign bus.hazir_o = (durum_q == HAZIR);
endmodule
